// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Shares one single-port 256 x 64 RAM between two requesters (m0, m1).
//   One access is accepted per cycle; the accepted command is registered onto
//   the RAM pins the following cycle, and read data is returned two cycles
//   after the grant with a one-cycle rvalid strobe to the requester that
//   issued the read.
//
// Parameters
//   FIXED_PRI  0 = round-robin on contention, 1 = m0 always wins contention
//
// Ports
//   clk, reset_n                 clock, asynchronous active-low reset
//   mX_req/wr/addr/wdata (in)    request, 1=write/0=read, word address, data
//   mX_grant (out)               combinational accept, only while mX_req high
//   mX_rvalid (out)              registered read-data strobe for requester X
//   mX_rdata (out)               RAM read data (same wire for both requesters)
//   cen, wen, s_addr, s_din      registered RAM command
//   s_dout (in)                  RAM read data, one clock after the read edge
//
// Handshake: a request is accepted in the cycle where mX_req and mX_grant are
// both high. The requester keeps wr/addr/wdata stable while mX_req is high and
// not yet granted; dropping mX_req before a grant withdraws the request.

module ram_arbiter #(
  parameter int unsigned FIXED_PRI = 0
) (
  input  logic        clk,
  input  logic        reset_n,

  input  logic        m0_req,
  input  logic        m0_wr,
  input  logic [7:0]  m0_addr,
  input  logic [63:0] m0_wdata,
  output logic        m0_grant,
  output logic        m0_rvalid,
  output logic [63:0] m0_rdata,

  input  logic        m1_req,
  input  logic        m1_wr,
  input  logic [7:0]  m1_addr,
  input  logic [63:0] m1_wdata,
  output logic        m1_grant,
  output logic        m1_rvalid,
  output logic [63:0] m1_rdata,

  output logic        cen,
  output logic        wen,
  output logic [7:0]  s_addr,
  output logic [63:0] s_din,
  input  logic [63:0] s_dout
);

  // Registered state
  logic        cen_q,      cen_d;
  logic        wen_q,      wen_d;
  logic [7:0]  s_addr_q,   s_addr_d;
  logic [63:0] s_din_q,    s_din_d;
  logic        rd_pend_q,  rd_pend_d;
  logic        rd_owner_q, rd_owner_d;
  logic        last_gnt_q, last_gnt_d;
  logic        m0_rvalid_q, m0_rvalid_d;
  logic        m1_rvalid_q, m1_rvalid_d;

  // Arbitration results for the current cycle
  logic        gnt0;
  logic        gnt1;
  logic        gnt_any;
  logic        gnt_idx;
  logic        sel_wr;
  logic [7:0]  sel_addr;
  logic [63:0] sel_wdata;

  // Grant decision. Grants are suppressed while reset is asserted so nothing
  // is accepted that the cleared issue stage would then lose.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (reset_n) begin
      if (m0_req && m1_req) begin
        if (FIXED_PRI != 0) begin
          gnt0 = 1'b1;
        end else if (last_gnt_q) begin
          // m1 won last time, so m0 goes now
          gnt0 = 1'b1;
        end else begin
          gnt1 = 1'b1;
        end
      end else begin
        gnt0 = m0_req;
        gnt1 = m1_req;
      end
    end
  end

  assign m0_grant = gnt0;
  assign m1_grant = gnt1;

  // Next-state for issue, read tracking and response stages
  always_comb begin
    gnt_any   = gnt0 | gnt1;
    gnt_idx   = gnt1;
    sel_wr    = gnt1 ? m1_wr    : m0_wr;
    sel_addr  = gnt1 ? m1_addr  : m0_addr;
    sel_wdata = gnt1 ? m1_wdata : m0_wdata;

    cen_d      = gnt_any;
    wen_d      = gnt_any & sel_wr;
    // Address and data hold when idle to avoid needless RAM pin toggling
    s_addr_d   = gnt_any ? sel_addr  : s_addr_q;
    s_din_d    = gnt_any ? sel_wdata : s_din_q;

    rd_pend_d  = gnt_any & ~sel_wr;
    rd_owner_d = (gnt_any & ~sel_wr) ? gnt_idx : rd_owner_q;
    last_gnt_d = gnt_any ? gnt_idx : last_gnt_q;

    // A read on the pins this cycle has its data on s_dout next cycle
    m0_rvalid_d = rd_pend_q & ~rd_owner_q;
    m1_rvalid_d = rd_pend_q &  rd_owner_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cen_q       <= 1'b0;
      wen_q       <= 1'b0;
      s_addr_q    <= 8'd0;
      s_din_q     <= 64'd0;
      rd_pend_q   <= 1'b0;
      rd_owner_q  <= 1'b0;
      last_gnt_q  <= 1'b1;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
    end else begin
      cen_q       <= cen_d;
      wen_q       <= wen_d;
      s_addr_q    <= s_addr_d;
      s_din_q     <= s_din_d;
      rd_pend_q   <= rd_pend_d;
      rd_owner_q  <= rd_owner_d;
      last_gnt_q  <= last_gnt_d;
      m0_rvalid_q <= m0_rvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
    end
  end

  assign cen       = cen_q;
  assign wen       = wen_q;
  assign s_addr    = s_addr_q;
  assign s_din     = s_din_q;
  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign m0_rdata  = s_dout;
  assign m1_rdata  = s_dout;

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter. Instance 0 is round-robin, instance 1 is fixed
// priority; each has its own behavioural RAM and its own request inputs.
module tb_ram_arbiter;

  localparam int N_RAND = 400;

  logic clk;
  logic reset_n;

  logic        req_i   [2][2];
  logic        wr_i    [2][2];
  logic [7:0]  addr_i  [2][2];
  logic [63:0] wdata_i [2][2];
  logic        gnt_o   [2][2];
  logic        rv_o    [2][2];
  logic [63:0] rdata_o [2][2];
  logic        cen_o   [2];
  logic        wen_o   [2];
  logic [7:0]  saddr_o [2];
  logic [63:0] sdin_o  [2];
  logic [63:0] sdout_w [2];

  int n_cmp;
  int n_fail;

  logic [63:0] model_mem [2][256];
  logic [97:0] exp_q [$];  // {inst, owner, due_cycle[31:0], data[63:0]}

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs + RAM models ----------------
  for (genvar k = 0; k < 2; k++) begin : g_dut
    logic [63:0] mem [256] = '{default: 64'd0};
    logic [63:0] dout_q;

    always @(posedge clk) begin
      if (cen_o[k]) begin
        if (wen_o[k]) mem[saddr_o[k]] <= sdin_o[k];
        else          dout_q <= mem[saddr_o[k]];
      end
    end
    assign sdout_w[k] = dout_q;

    ram_arbiter #(.FIXED_PRI(k)) u_dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .m0_req    (req_i[k][0]),
      .m0_wr     (wr_i[k][0]),
      .m0_addr   (addr_i[k][0]),
      .m0_wdata  (wdata_i[k][0]),
      .m0_grant  (gnt_o[k][0]),
      .m0_rvalid (rv_o[k][0]),
      .m0_rdata  (rdata_o[k][0]),
      .m1_req    (req_i[k][1]),
      .m1_wr     (wr_i[k][1]),
      .m1_addr   (addr_i[k][1]),
      .m1_wdata  (wdata_i[k][1]),
      .m1_grant  (gnt_o[k][1]),
      .m1_rvalid (rv_o[k][1]),
      .m1_rdata  (rdata_o[k][1]),
      .cen       (cen_o[k]),
      .wen       (wen_o[k]),
      .s_addr    (saddr_o[k]),
      .s_din     (sdin_o[k]),
      .s_dout    (sdout_w[k])
    );
  end

  // ---------------- helpers ----------------
  function automatic logic [1:0] gnt_of(input int k);
    return {gnt_o[k][1], gnt_o[k][0]};
  endfunction

  function automatic logic [1:0] rv_of(input int k);
    return {rv_o[k][1], rv_o[k][0]};
  endfunction

  // Reference arbitration rule: one-hot {m1,m0} grant
  function automatic logic [1:0] ref_grant(input int k, input logic a, input logic b,
                                           input logic last);
    if (a && b) begin
      if (k == 1) return 2'b01;
      return last ? 2'b01 : 2'b10;
    end
    if (a) return 2'b01;
    if (b) return 2'b10;
    return 2'b00;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_m(input int r, input logic req, input logic wr,
                         input logic [7:0] addr, input logic [63:0] data);
    for (int k = 0; k < 2; k++) begin
      req_i[k][r]   = req;
      wr_i[k][r]    = wr;
      addr_i[k][r]  = addr;
      wdata_i[k][r] = data;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    drive_m(0, 1'b1, 1'b0, 8'd0, 64'd0);
    drive_m(1, 1'b1, 1'b0, 8'd1, 64'd0);
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (gnt_of(k) !== 2'b00) begin
        n_fail++; $display("FAIL reset_gnt k=%0d got=%b exp=00", k, gnt_of(k));
      end
      n_cmp++;
      if ({cen_o[k], wen_o[k]} !== 2'b00) begin
        n_fail++; $display("FAIL reset_cen_wen k=%0d got=%b exp=00", k, {cen_o[k], wen_o[k]});
      end
      n_cmp++;
      if (saddr_o[k] !== 8'd0 || sdin_o[k] !== 64'd0) begin
        n_fail++; $display("FAIL reset_addr_din k=%0d got=%h/%h exp=0/0", k, saddr_o[k], sdin_o[k]);
      end
      n_cmp++;
      if (rv_of(k) !== 2'b00) begin
        n_fail++; $display("FAIL reset_rvalid k=%0d got=%b exp=00", k, rv_of(k));
      end
    end
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (gnt_of(k) !== 2'b01) begin
        n_fail++; $display("FAIL reset_first_gnt k=%0d got=%b exp=01", k, gnt_of(k));
      end
    end
    step();
    drive_m(0, 1'b0, 1'b0, 8'd0, 64'd0);
    drive_m(1, 1'b0, 1'b0, 8'd0, 64'd0);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (gnt_of(k) !== 2'b00) begin
        n_fail++; $display("FAIL dropped_req_gnt k=%0d got=%b exp=00", k, gnt_of(k));
      end
      n_cmp++;
      if ({cen_o[k], wen_o[k], saddr_o[k]} !== {2'b10, 8'd0}) begin
        n_fail++; $display("FAIL first_issue k=%0d got=%b%b/%h exp=10/00", k, cen_o[k], wen_o[k], saddr_o[k]);
      end
    end
    step();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (rv_of(k) !== 2'b01 || rdata_o[k][0] !== 64'd0) begin
        n_fail++; $display("FAIL first_read_resp k=%0d got=%b/%h exp=01/0", k, rv_of(k), rdata_o[k][0]);
      end
    end
    step();
  endtask

  task automatic test_single_path();
    drive_m(0, 1'b1, 1'b1, 8'h05, 64'h78);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (gnt_of(k) !== 2'b01) begin
        n_fail++; $display("FAIL sp_wr_gnt k=%0d got=%b exp=01", k, gnt_of(k));
      end
    end
    step();
    drive_m(0, 1'b0, 1'b0, 8'd0, 64'd0);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if ({cen_o[k], wen_o[k], saddr_o[k], sdin_o[k]} !== {2'b11, 8'h05, 64'h78}) begin
        n_fail++; $display("FAIL sp_wr_issue k=%0d got=%b%b/%h/%h exp=11/05/78", k, cen_o[k], wen_o[k], saddr_o[k], sdin_o[k]);
      end
    end
    step();
    drive_m(0, 1'b1, 1'b0, 8'h05, 64'd0);
    @(negedge clk);
    step();
    drive_m(0, 1'b0, 1'b0, 8'd0, 64'd0);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (rv_of(k) !== 2'b00 || {cen_o[k], wen_o[k]} !== 2'b10) begin
        n_fail++; $display("FAIL sp_rd_issue k=%0d got=rv%b cw%b%b exp=rv00 cw10", k, rv_of(k), cen_o[k], wen_o[k]);
      end
    end
    step();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (rv_of(k) !== 2'b01 || rdata_o[k][0] !== 64'h78) begin
        n_fail++; $display("FAIL sp_rd_resp k=%0d got=%b/%h exp=01/78", k, rv_of(k), rdata_o[k][0]);
      end
    end
    step();
  endtask

  task automatic test_contention();
    logic [1:0]  seq [2][8];
    logic [1:0]  eg;
    logic [63:0] da;
    logic [63:0] db;
    da = 64'hA5A5_0000_0000_0010;
    db = 64'h5A5A_0000_0000_0020;
    seq[0] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00};
    seq[1] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00};
    drive_m(0, 1'b1, 1'b1, 8'd10, da);
    step();
    drive_m(0, 1'b0, 1'b0, 8'd0, 64'd0);
    drive_m(1, 1'b1, 1'b1, 8'd20, db);
    step();
    drive_m(1, 1'b0, 1'b0, 8'd0, 64'd0);
    step();
    for (int c = 0; c < 8; c++) begin
      drive_m(0, (c < 4), 1'b0, 8'd10, 64'd0);
      drive_m(1, (c < 5), 1'b0, 8'd20, 64'd0);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (gnt_of(k) !== seq[k][c]) begin
          n_fail++; $display("FAIL cont_gnt k=%0d c=%0d got=%b exp=%b", k, c, gnt_of(k), seq[k][c]);
        end
        if (c >= 2) begin
          eg = seq[k][c-2];
          n_cmp++;
          if (rv_of(k) !== eg) begin
            n_fail++; $display("FAIL cont_rvalid k=%0d c=%0d got=%b exp=%b", k, c, rv_of(k), eg);
          end
          if (eg == 2'b01) begin
            n_cmp++;
            if (rdata_o[k][0] !== da) begin
              n_fail++; $display("FAIL cont_rdata0 k=%0d c=%0d got=%h exp=%h", k, c, rdata_o[k][0], da);
            end
          end
          if (eg == 2'b10) begin
            n_cmp++;
            if (rdata_o[k][1] !== db) begin
              n_fail++; $display("FAIL cont_rdata1 k=%0d c=%0d got=%h exp=%h", k, c, rdata_o[k][1], db);
            end
          end
        end
      end
      step();
    end
  endtask

  task automatic test_pipelined();
    drive_m(1, 1'b1, 1'b1, 8'hFF, {64{1'b1}});
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (gnt_of(k) !== 2'b10) begin
        n_fail++; $display("FAIL pipe_wr_gnt k=%0d got=%b exp=10", k, gnt_of(k));
      end
    end
    step();
    drive_m(1, 1'b1, 1'b0, 8'hFF, 64'd0);
    @(negedge clk);
    step();
    drive_m(1, 1'b0, 1'b0, 8'd0, 64'd0);
    drive_m(0, 1'b1, 1'b0, 8'h00, 64'd0);
    @(negedge clk);
    step();
    drive_m(0, 1'b0, 1'b0, 8'd0, 64'd0);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (rv_of(k) !== 2'b10 || rdata_o[k][1] !== {64{1'b1}}) begin
        n_fail++; $display("FAIL pipe_raw_255 k=%0d got=%b/%h exp=10/ffffffffffffffff", k, rv_of(k), rdata_o[k][1]);
      end
    end
    step();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (rv_of(k) !== 2'b01 || rdata_o[k][0] !== 64'd0) begin
        n_fail++; $display("FAIL pipe_rd_0 k=%0d got=%b/%h exp=01/0", k, rv_of(k), rdata_o[k][0]);
      end
    end
    step();
  endtask

  task automatic test_reset_mid_read();
    drive_m(0, 1'b1, 1'b0, 8'h05, 64'd0);
    @(negedge clk);
    step();
    drive_m(0, 1'b0, 1'b0, 8'd0, 64'd0);
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (cen_o[k] !== 1'b1) begin
        n_fail++; $display("FAIL mid_pre_cen k=%0d got=%b exp=1", k, cen_o[k]);
      end
    end
    #1 reset_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (cen_o[k] !== 1'b0 || rv_of(k) !== 2'b00) begin
        n_fail++; $display("FAIL mid_async_clear k=%0d got=cen%b rv%b exp=cen0 rv00", k, cen_o[k], rv_of(k));
      end
    end
    for (int c = 0; c < 3; c++) begin
      step();
      if (c == 0) reset_n = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (rv_of(k) !== 2'b00 || cen_o[k] !== 1'b0) begin
          n_fail++; $display("FAIL mid_no_resp k=%0d c=%0d got=rv%b cen%b exp=rv00 cen0", k, c, rv_of(k), cen_o[k]);
        end
      end
    end
    step();
  endtask

  task automatic test_random();
    bit          pend [2][2];
    logic        last [2];
    logic [1:0]  pg   [2];
    logic        pwr  [2];
    logic [7:0]  pa   [2];
    logic [63:0] pd   [2];
    logic [1:0]  eg;
    logic [1:0]  er;
    logic [63:0] ed;
    logic        own;
    logic [7:0]  a;
    logic [31:0] cyc;
    int          hit;

    reset_n = 1'b0;
    drive_m(0, 1'b0, 1'b0, 8'd0, 64'd0);
    drive_m(1, 1'b0, 1'b0, 8'd0, 64'd0);
    step();
    reset_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      last[k] = 1'b1;
      pg[k]   = 2'b00;
      pwr[k]  = 1'b0;
      pa[k]   = 8'd0;
      pd[k]   = 64'd0;
      for (int r = 0; r < 2; r++) pend[k][r] = 1'b0;
      for (int i = 32; i < 48; i++) model_mem[k][i] = 64'd0;
    end
    exp_q.delete();

    for (int n = 0; n < N_RAND + 3; n++) begin
      cyc = 32'(n);
      for (int k = 0; k < 2; k++) begin
        for (int r = 0; r < 2; r++) begin
          if (n >= N_RAND) begin
            req_i[k][r] = 1'b0;
          end else if (pend[k][r]) begin
            // keep the held request, or occasionally withdraw it
            if ($urandom_range(0, 15) == 0) req_i[k][r] = 1'b0;
          end else begin
            req_i[k][r]   = ($urandom_range(0, 3) != 0);
            wr_i[k][r]    = 1'($urandom_range(0, 1));
            addr_i[k][r]  = 8'd32 + 8'($urandom_range(0, 15));
            wdata_i[k][r] = {$urandom, $urandom};
          end
        end
      end
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        eg = ref_grant(k, req_i[k][0], req_i[k][1], last[k]);
        n_cmp++;
        if (gnt_of(k) !== eg) begin
          n_fail++; $display("FAIL rand_gnt k=%0d cyc=%0d got=%b exp=%b", k, n, gnt_of(k), eg);
        end
        n_cmp++;
        if ({cen_o[k], wen_o[k]} !== {(pg[k] != 2'b00), (pg[k] != 2'b00) && pwr[k]}) begin
          n_fail++; $display("FAIL rand_cmd k=%0d cyc=%0d got=%b%b exp=%b%b", k, n, cen_o[k], wen_o[k],
                             (pg[k] != 2'b00), (pg[k] != 2'b00) && pwr[k]);
        end
        if (pg[k] != 2'b00) begin
          n_cmp++;
          if (saddr_o[k] !== pa[k] || (pwr[k] && sdin_o[k] !== pd[k])) begin
            n_fail++; $display("FAIL rand_addr_din k=%0d cyc=%0d got=%h/%h exp=%h/%h", k, n, saddr_o[k], sdin_o[k], pa[k], pd[k]);
          end
        end
        er  = 2'b00;
        ed  = 64'd0;
        hit = -1;
        foreach (exp_q[i]) begin
          if (exp_q[i][97] == 1'(k) && exp_q[i][95:64] == cyc) hit = i;
        end
        if (hit >= 0) begin
          er = exp_q[hit][96] ? 2'b10 : 2'b01;
          ed = exp_q[hit][63:0];
          exp_q.delete(hit);
        end
        n_cmp++;
        if (rv_of(k) !== er) begin
          n_fail++; $display("FAIL rand_rvalid k=%0d cyc=%0d got=%b exp=%b", k, n, rv_of(k), er);
        end
        if (er != 2'b00) begin
          n_cmp++;
          if (rdata_o[k][er[1]] !== ed) begin
            n_fail++; $display("FAIL rand_rdata k=%0d cyc=%0d got=%h exp=%h", k, n, rdata_o[k][er[1]], ed);
          end
        end
        // reference model update: accesses take effect in grant order
        pg[k] = eg;
        if (eg != 2'b00) begin
          own     = eg[1];
          last[k] = own;
          pwr[k]  = wr_i[k][own];
          a       = addr_i[k][own];
          pa[k]   = a;
          pd[k]   = wdata_i[k][own];
          if (wr_i[k][own]) model_mem[k][a] = wdata_i[k][own];
          else exp_q.push_back({1'(k), own, cyc + 32'd2, model_mem[k][a]});
        end
        pend[k][0] = req_i[k][0] && !eg[0];
        pend[k][1] = req_i[k][1] && !eg[1];
      end
      step();
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL rand_outstanding got=%0d exp=0", exp_q.size());
    end
  endtask

  // ---------------- main sequence + report ----------------
  initial begin
    n_cmp  = 0;
    n_fail = 0;
    reset_n = 1'b0;
    drive_m(0, 1'b0, 1'b0, 8'd0, 64'd0);
    drive_m(1, 1'b0, 1'b0, 8'd0, 64'd0);
    test_reset();
    test_single_path();
    test_contention();
    test_pipelined();
    test_reset_mid_read();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter and sequencer sharing the single-port 256 x 64 on-chip RAM between two requesters, for example the factorial core and the host/load path. It accepts one request per cycle with a req/grant handshake and registers the RAM command (cen, wen, s_addr, s_din). It tracks which requester owns each in-flight read and returns read data with a one-cycle rvalid strobe to that requester only. Arbitration is round-robin or fixed-priority, selected by parameter.

## Interface
- FIXED_PRI, 0, 0 = round-robin between m0 and m1; 1 = m0 always wins contention
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- m0_req  in  1  requester 0 access request, held until granted
- m0_wr  in  1  1 = write, 0 = read; stable while m0_req high
- m0_addr  in  8  word address
- m0_wdata  in  64  write data
- m0_grant  out  1  combinational; request accepted this cycle
- m0_rvalid  out  1  registered; read data for m0 valid this cycle
- m0_rdata  out  64  read data; equals s_dout, meaningful only with m0_rvalid
- m1_req, m1_wr, m1_addr, m1_wdata, m1_grant, m1_rvalid, m1_rdata  same as m0 for requester 1
- cen  out  1  registered RAM chip enable
- wen  out  1  registered RAM write enable
- s_addr  out  8  registered RAM address
- s_din  out  64  registered RAM write data
- s_dout  in  64  RAM read data, valid one clock after a read command is sampled

## Operation
- Arbitration is combinational in the accept cycle, with at most one grant per cycle. mX_grant is high only if mX_req is high.
- Only one requester active: that requester is granted.
- Both active, FIXED_PRI=0: grant the requester not in last_gnt. FIXED_PRI=1: grant m0.
- last_gnt register updates to the granted index on every grant. Its reset value is 1, so m0 wins the first contention.
- Issue stage: on a grant, the next edge loads cen=1, wen=granted wr, s_addr=addr, s_din=wdata. With no grant, the next edge loads cen=0 and wen=0; s_addr and s_din hold their values.
- Read tracking: on an edge where a read is issued (cen=1, wen=0 loaded), also load rd_pend=1 and rd_owner=granted index. Otherwise load rd_pend=0.
- Response stage: on the edge after rd_pend=1, set mX_rvalid=1 for X=rd_owner, 0 for the other. Both rvalid are 0 when rd_pend was 0.
- Writes produce no response.
- m0_rdata and m1_rdata are both wired to s_dout. No extra register.
- No internal FSM stalls. Throughput is one access per cycle, sustained, any read/write mix, both requesters.
- Read-after-write to the same address in consecutive grants returns the new data. The RAM commits the write at the issue edge, before the read is sampled.

## Timing
- Reset (reset_n low, asynchronous) drives the following. All are cleared immediately and held while reset_n is low:
  - cen=0, wen=0, s_addr=0, s_din=0
  - rd_pend=0, rd_owner=0, last_gnt=1
  - m0_rvalid=m1_rvalid=0
- Grants are 0 whenever reset_n is low.
- Read latency, grant in cycle T:
  - command on RAM pins during T+1
  - RAM samples at end of T+1
  - mX_rvalid=1 and s_dout valid during T+2
- Write latency: the RAM is written at the end of T+1.
- Back-to-back reads granted at T, T+1, T+2 give rvalid at T+2, T+3, T+4, each to its own owner, in grant order.
- Reset mid-operation: in-flight commands and pending responses are discarded, with no rvalid after reset. A write already sampled by the RAM stays committed.
- Request dropped before grant: no access. Requesters must not change wr/addr/wdata while req is high and ungranted.
- Address wrap: addresses are 8-bit, and 255 and 0 are ordinary addresses with no special handling.

## Test plan
- Reset: hold reset_n low with both req high. Required: all grants, cen, wen and rvalid are 0. Release reset; m0 is granted first.
- Single path:
  - m0 writes 64'h0000_0000_0000_0078 to addr 8'h05 in cycle T. Required: cen=1, wen=1, s_addr=5 during T+1.
  - m0 reads addr 5 in T+2. Required: m0_rvalid=1, m0_rdata=64'h78 in T+4, and m1_rvalid=0.
- Contention, FIXED_PRI=0: both hold read req for 4 cycles. Required: grants alternate m0, m1, m0, m1, and rvalid alternates the same way 2 cycles later.
- Contention, FIXED_PRI=1: both hold req. Required: m0 is granted every cycle and m1 only after m0_req drops.
- Pipelined mixed traffic:
  - m1 writes addr 255 = 64'hFFFF_FFFF_FFFF_FFFF in T, then reads 255 in T+1. Required: m1_rvalid in T+3 with all-ones data.
  - m0 reads addr 0 (initial 0) in T+2. Required: m0_rvalid with 0 in T+4.
- Reset mid-read: grant an m0 read at T and assert reset_n low in T+1. Required: no rvalid in T+2 or later, and cen=0 immediately.
